// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the multiply/divide sequencer:
//   state_t           - sequencer FSM state encoding
//   OP_MULT / OP_DIV  - encoding of the op_sel request field
//   DEFAULT_*         - default unit latencies and counter width
// -----------------------------------------------------------------------------
package muldiv_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RUN     = 3'd2,
        CAPTURE = 3'd3,
        ABORT   = 3'd4
    } state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int DEFAULT_MULT_CYCLES = 32;
    localparam int DEFAULT_DIV_CYCLES  = 32;
    localparam int DEFAULT_CNT_W       = 6;

endpackage

// File: rtl/muldiv_cycle_counter.sv
// -----------------------------------------------------------------------------
// muldiv_cycle_counter
// Loadable down-counter with a zero flag. Stops at zero instead of wrapping.
// Ports:
//   clock, reset  - clock and asynchronous active-high reset
//   load          - load load_value (has priority over dec)
//   load_value    - value to load
//   dec           - decrement by one while non-zero
//   zero          - count is zero
// -----------------------------------------------------------------------------
module muldiv_cycle_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
// Sequences the shared iterative multiplier and divider for the multicycle
// control unit: accepts one MULT/DIV request, pulses the selected unit's start,
// waits its fixed latency and captures its Hi/Lo into the architectural HI/LO.
// Divide-by-zero is resolved in IDLE without starting the divider.
//
// Optional build macro MULT_ZERO_SKIP_EN: a MULT with a zero operand completes
// directly from IDLE with HI = LO = 0 and never starts the multiplier.
//
// Ports:
//   clock, reset            - clock, asynchronous active-high reset
//   op_start, op_sel        - request strobe (IDLE only), 0 = MULT, 1 = DIV
//   op_a, op_b              - operands
//   abort                   - flush the in-flight operation
//   mult_ctrl, div_ctrl     - one-cycle unit start pulses
//   unit_reset              - reset to both units
//   unit_a, unit_b          - registered operands to the units
//   mult_hi/lo, div_hi/lo   - unit results
//   busy, done, div_zero    - status (done/div_zero are one-cycle pulses)
//   hi, lo                  - architectural HI/LO
//
// MULT_CYCLES and DIV_CYCLES must be at least 2.
// -----------------------------------------------------------------------------
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES,
    parameter int CNT_W       = DEFAULT_CNT_W
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        op_start,
    input  logic        op_sel,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        abort,
    output logic        mult_ctrl,
    output logic        div_ctrl,
    output logic        unit_reset,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // The counter is loaded on the accepting edge and also decrements on the
    // LOAD edge, so it reaches zero one edge before the unit result is valid;
    // the RUN -> CAPTURE edge then lands on the unit's final step and the
    // CAPTURE edge samples settled results.
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    state_t state;
    logic   sel_q;

    logic   div_by_zero_req;
    logic   skip_req;
    logic   full_req;
    logic   cnt_load;
    logic   cnt_dec;
    logic   cnt_zero;

    assign div_by_zero_req = op_start && (op_sel == OP_DIV) && (op_b == 32'd0);

`ifdef MULT_ZERO_SKIP_EN
    assign skip_req = op_start && (op_sel == OP_MULT) &&
                      ((op_a == 32'd0) || (op_b == 32'd0));
`else
    assign skip_req = 1'b0;
`endif

    assign full_req = op_start && !div_by_zero_req && !skip_req;

    assign cnt_load = (state == IDLE) && full_req;
    assign cnt_dec  = (state == LOAD) || (state == RUN);

    muldiv_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clock      (clock),
        .reset      (reset),
        .load       (cnt_load),
        .load_value ((op_sel == OP_DIV) ? DIV_LOAD : MULT_LOAD),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    // Units are held in reset during reset and for the single ABORT cycle.
    assign unit_reset = reset || (state == ABORT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sel_q     <= OP_MULT;
            unit_a    <= 32'd0;
            unit_b    <= 32'd0;
            hi        <= 32'd0;
            lo        <= 32'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            mult_ctrl <= 1'b0;
            div_ctrl  <= 1'b0;
        end else begin
            done      <= 1'b0;
            div_zero  <= 1'b0;
            mult_ctrl <= 1'b0;
            div_ctrl  <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (full_req) begin
                        unit_a    <= op_a;
                        unit_b    <= op_b;
                        sel_q     <= op_sel;
                        mult_ctrl <= (op_sel == OP_MULT);
                        div_ctrl  <= (op_sel == OP_DIV);
                        busy      <= 1'b1;
                        state     <= LOAD;
                    end else if (div_by_zero_req) begin
                        done     <= 1'b1;
                        div_zero <= 1'b1;
                    end else if (skip_req) begin
                        hi   <= 32'd0;
                        lo   <= 32'd0;
                        done <= 1'b1;
                    end
                end

                LOAD: begin
                    state <= abort ? ABORT : RUN;
                end

                RUN: begin
                    if (abort) begin
                        state <= ABORT;
                    end else if (cnt_zero) begin
                        state <= CAPTURE;
                    end
                end

                CAPTURE: begin
                    if (abort) begin
                        state <= ABORT;
                    end else begin
                        hi    <= (sel_q == OP_DIV) ? div_hi : mult_hi;
                        lo    <= (sel_q == OP_DIV) ? div_lo : mult_lo;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                ABORT: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
// Self-checking bench for muldiv_sequencer. Behavioural multiplier/divider
// models drive the unit result ports (results only valid after the unit's
// full latency); expected outcomes come from the request-level timing rules.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

    localparam int  MULT_CYCLES = 32;
    localparam int  DIV_CYCLES  = 32;
`ifdef MULT_ZERO_SKIP_EN
    localparam bit  SKIP_EN = 1'b1;
`else
    localparam bit  SKIP_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        op_start = 1'b0;
    logic        op_sel = 1'b0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        abort = 1'b0;
    logic        mult_ctrl, div_ctrl, unit_reset;
    logic [31:0] unit_a, unit_b;
    logic [31:0] mult_hi, mult_lo, div_hi, div_lo;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int passed = 0;
    int total  = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    always #5 clock = ~clock;

    muldiv_sequencer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (6)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .op_start   (op_start),
        .op_sel     (op_sel),
        .op_a       (op_a),
        .op_b       (op_b),
        .abort      (abort),
        .mult_ctrl  (mult_ctrl),
        .div_ctrl   (div_ctrl),
        .unit_reset (unit_reset),
        .unit_a     (unit_a),
        .unit_b     (unit_b),
        .mult_hi    (mult_hi),
        .mult_lo    (mult_lo),
        .div_hi     (div_hi),
        .div_lo     (div_lo),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .hi         (hi),
        .lo         (lo)
    );

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] x;
        logic signed [63:0] y;
        x = 64'(signed'(a));
        y = 64'(signed'(b));
        return x * y;
    endfunction

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] q;
        logic signed [31:0] r;
        q = signed'(a) / signed'(b);
        r = signed'(a) % signed'(b);
        return {r, q};
    endfunction

    // Behavioural units: start edge counts as step 1, result appears after the
    // final step; before that the outputs carry junk.
    logic [31:0] m_a, m_b, d_a, d_b;
    int          m_step = 0;
    int          d_step = 0;

    always @(posedge clock) begin
        if (unit_reset) begin
            m_step  <= 0;
            d_step  <= 0;
            mult_hi <= 32'hBAD0_0000;
            mult_lo <= 32'hBAD0_0001;
            div_hi  <= 32'hBAD0_0002;
            div_lo  <= 32'hBAD0_0003;
        end else begin
            if (mult_ctrl) begin
                m_a     <= unit_a;
                m_b     <= unit_b;
                m_step  <= 1;
                mult_hi <= $urandom;
                mult_lo <= $urandom;
            end else if (m_step > 0 && m_step < MULT_CYCLES) begin
                m_step <= m_step + 1;
                if (m_step + 1 == MULT_CYCLES) {mult_hi, mult_lo} <= ref_mul(m_a, m_b);
                else begin
                    mult_hi <= $urandom;
                    mult_lo <= $urandom;
                end
            end
            if (div_ctrl) begin
                d_a    <= unit_a;
                d_b    <= unit_b;
                d_step <= 1;
                div_hi <= $urandom;
                div_lo <= $urandom;
            end else if (d_step > 0 && d_step < DIV_CYCLES) begin
                d_step <= d_step + 1;
                if (d_step + 1 == DIV_CYCLES) {div_hi, div_lo} <= ref_div(d_a, d_b);
                else begin
                    div_hi <= $urandom;
                    div_lo <= $urandom;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Issue one request from the current negedge and follow it to completion.
    // abort_at / poke_at: negedge index (1 = cycle after the accepting edge)
    // at which to raise abort / a stray op_start for one cycle; 0 = never.
    // Returns at the negedge of the done cycle (or after the watch window).
    task automatic run_op(input string tag, input logic sel, input logic [31:0] a,
                          input logic [31:0] b, input int abort_at, input int poke_at);
        int          exp_n, exp_busy, exp_pulses, limit;
        int          dn = 0, bc = 0, mp = 0, dp = 0;
        logic        ur_seen = 1'b0;
        logic        dz_seen = 1'b0;
        logic        exp_dz = 1'b0;
        logic        full = 1'b0;
        logic [63:0] res;

        if (sel && b == 32'd0) begin
            exp_n = 1; exp_busy = 0; exp_pulses = 0; exp_dz = 1'b1;
            res = {model_hi, model_lo};
        end else if (SKIP_EN && !sel && (a == 32'd0 || b == 32'd0)) begin
            exp_n = 1; exp_busy = 0; exp_pulses = 0;
            res = 64'd0;
        end else begin
            full = 1'b1;
            exp_pulses = 1;
            if (abort_at > 0) begin
                exp_n = 0; exp_busy = abort_at + 1;
                res = {model_hi, model_lo};
            end else begin
                exp_n    = (sel ? DIV_CYCLES : MULT_CYCLES) + 2;
                exp_busy = exp_n - 1;
                res      = sel ? ref_div(a, b) : ref_mul(a, b);
            end
        end

        op_start = 1'b1; op_sel = sel; op_a = a; op_b = b;
        @(posedge clock);
        #1;
        op_start = 1'b0; op_a = $urandom; op_b = $urandom;

        limit = (exp_n == 0) ? 45 : exp_n + 8;
        for (int n = 1; n <= limit; n++) begin
            @(negedge clock);
            if (mult_ctrl) mp++;
            if (div_ctrl) dp++;
            if (busy) bc++;
            if (n == abort_at + 1 && abort_at > 0) ur_seen = unit_reset;
            if (abort_at > 0 && n == abort_at) abort = 1'b1;
            if (abort_at > 0 && n == abort_at + 1) abort = 1'b0;
            if (poke_at > 0 && n == poke_at) op_start = 1'b1;
            if (poke_at > 0 && n == poke_at + 1) op_start = 1'b0;
            if (done) begin
                dn = n;
                dz_seen = div_zero;
                break;
            end
        end
        abort = 1'b0;
        op_start = 1'b0;

        check({tag, " done_cycle"}, 64'(dn), 64'(exp_n));
        check({tag, " busy_cycles"}, 64'(bc), 64'(exp_busy));
        check({tag, " mult_pulses"}, 64'(mp), sel ? 64'd0 : 64'(exp_pulses));
        check({tag, " div_pulses"}, 64'(dp), sel ? 64'(exp_pulses) : 64'd0);
        check({tag, " hi_lo"}, {hi, lo}, res);
        if (dn > 0) check({tag, " div_zero"}, 64'(dz_seen), 64'(exp_dz));
        if (abort_at > 0) check({tag, " unit_reset_abort"}, 64'(ur_seen), 64'd1);
        if (full) check({tag, " operands_held"}, {unit_a, unit_b}, {a, b});
        model_hi = res[63:32];
        model_lo = res[31:0];
    endtask

    initial begin
        logic        sel;
        logic [31:0] a, b;

        // Reset state
        repeat (2) @(negedge clock);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'({done, div_zero}), 64'd0);
        check("rst ctrl", 64'({mult_ctrl, div_ctrl}), 64'd0);
        check("rst unit_reset", 64'(unit_reset), 64'd1);
        check("rst hi_lo", {hi, lo}, 64'd0);
        check("rst operands", {unit_a, unit_b}, 64'd0);
        reset = 1'b0;
        @(negedge clock);
        check("idle unit_reset", 64'(unit_reset), 64'd0);

        run_op("mul7x6", 1'b0, 32'd7, 32'd6, 0, 0);
        @(negedge clock);
        check("mul7x6 done_pulse", 64'({done, busy}), 64'd0);

        run_op("mul_neg1x2", 1'b0, 32'hFFFF_FFFF, 32'd2, 0, 0);
        @(negedge clock);
        run_op("div100by0", 1'b1, 32'd100, 32'd0, 0, 0);
        @(negedge clock);
        check("div100by0 pulse_width", 64'({done, div_zero}), 64'd0);

        // Back-to-back: new request issued in the done cycle
        run_op("div100by7", 1'b1, 32'd100, 32'd7, 0, 0);
        run_op("b2b_mul", 1'b0, 32'h1234_5678, 32'hFEDC_BA98, 0, 0);
        @(negedge clock);

        // Aborts: mid-RUN with a stray op_start, during CAPTURE, during LOAD
        run_op("abort_run", 1'b0, 32'd3, 32'd5, 10, 5);
        @(negedge clock);
        run_op("abort_capture", 1'b1, 32'd999, 32'd10, 33, 0);
        @(negedge clock);
        run_op("abort_load", 1'b0, 32'd11, 32'd13, 1, 0);
        @(negedge clock);

        // Abort while idle does nothing
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort_idle busy_ur", 64'({busy, unit_reset}), 64'd0);
        check("abort_idle hi_lo", {hi, lo}, {model_hi, model_lo});

        // Randomized requests
        for (int i = 0; i < 6; i++) begin
            sel = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            if (b == 32'd0 || b == 32'hFFFF_FFFF) b = 32'd3;
            run_op($sformatf("rand%0d", i), sel, a, b, 0, 0);
            @(negedge clock);
        end

        run_op("mul0x5", 1'b0, 32'd0, 32'd5, 0, 0);
        @(negedge clock);

        // Asynchronous reset in the middle of RUN
        op_start = 1'b1; op_sel = 1'b0; op_a = 32'd9; op_b = 32'd9;
        @(posedge clock);
        #1 op_start = 1'b0;
        repeat (10) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("async_rst busy", 64'({busy, mult_ctrl, done}), 64'd0);
        check("async_rst hi_lo", {hi, lo}, 64'd0);
        check("async_rst unit_reset", 64'(unit_reset), 64'd1);
        @(negedge clock);
        reset = 1'b0;
        model_hi = 32'd0;
        model_lo = 32'd0;
        repeat (3) @(negedge clock);
        check("after_rst idle", 64'({busy, done}), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
